hazard_ctrl_unit: RTL

Parametrised, stateful successor to the pipeline's combinational hazard unit for the 5-stage MIPS core. Handles multi-cycle load-use stalls, a multi-cycle mult/div busy interlock, ID-stage jumps, EX-stage taken branches and exception flushes. Drives the PC, IF/ID, ID/EX and EX/MEM stall/flush controls and exposes a stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_ctrl_unit_if.sv | 53 +++++
 rtl/hazard_down_counter.sv | 40 ++++
 rtl/hazard_ctrl_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit.
// PCSrc encodings, control bundle type and counter width helper.
package hazard_pkg;

  localparam int PCSRC_BRANCH = 1;
  localparam int PCSRC_J      = 2;
  localparam int PCSRC_JAL    = 3;
  localparam int PCSRC_JR     = 4;
  localparam int PCSRC_JALR   = 5;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } hz_ctl_t;

  function automatic int cnt_w(input int maxv);
    return (maxv < 2) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard unit signal bundle.
// master = pipeline side, slave = hazard unit side.
interface hazard_ctrl_unit_if #(
  parameter int REG_W   = 5,
  parameter int PCSRC_W = 3,
  parameter int CNT_W   = 32
);

  logic               id_ex_mem_read;
  logic [REG_W-1:0]   id_ex_rt;
  logic [REG_W-1:0]   if_id_rs;
  logic [REG_W-1:0]   if_id_rt;
  logic [PCSRC_W-1:0] id_pcsrc;
  logic [PCSRC_W-1:0] id_ex_pcsrc;
  logic               ex_alu_out0;
  logic               id_md_start;
  logic               id_md_use;
  logic               exc_req;
  logic               pc_write;
  logic               if_id_write;
  logic               if_id_flush;
  logic               id_ex_flush;
  logic               ex_mem_flush;
  logic               md_busy;
  logic [CNT_W-1:0]   stall_cycles;

  modport master (
    output id_ex_mem_read, id_ex_rt,
    output if_id_rs, if_id_rt,
    output id_pcsrc, id_ex_pcsrc,
    output ex_alu_out0,
    output id_md_start, id_md_use,
    output exc_req,
    input  pc_write, if_id_write,
    input  if_id_flush, id_ex_flush,
    input  ex_mem_flush, md_busy,
    input  stall_cycles
  );

  modport slave (
    input  id_ex_mem_read, id_ex_rt,
    input  if_id_rs, if_id_rt,
    input  id_pcsrc, id_ex_pcsrc,
    input  ex_alu_out0,
    input  id_md_start, id_md_use,
    input  exc_req,
    output pc_write, if_id_write,
    output if_id_flush, id_ex_flush,
    output ex_mem_flush, md_busy,
    output stall_cycles
  );

endinterface

// File: rtl/hazard_down_counter.sv
// Loadable down counter that stops at zero.
// Clear beats load; load beats decrement.
module hazard_down_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clr_i,
  output logic         nz_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, load or step toward zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nz_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stateful hazard unit: load-use and mult/div interlocks,
// jump/branch/exception flushes and a stall-cycle counter.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int PCSRC_W  = 3,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 32,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  hazard_ctrl_unit_if.slave  hz
);

  localparam int LU_W = cnt_w(LOAD_LAT - 1);
  localparam int MD_W = cnt_w(MD_LAT);

  logic [REG_W-1:0]   ex_rt;
  logic [REG_W-1:0]   id_rs;
  logic [REG_W-1:0]   id_rt;
  logic [PCSRC_W-1:0] ipc;
  logic [PCSRC_W-1:0] epc;

  logic lu_hit;
  logic lu_nz;
  logic lu_stall;
  logic md_nz;
  logic md_stall;
  logic stall;
  logic br_taken;
  logic jump;
  logic lu_load;
  logic lu_clr;
  logic md_load;

  hz_ctl_t ctl;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;

  assign ex_rt = hz.id_ex_rt;
  assign id_rs = hz.if_id_rs;
  assign id_rt = hz.if_id_rt;
  assign ipc   = hz.id_pcsrc;
  assign epc   = hz.id_ex_pcsrc;

  assign lu_hit = hz.id_ex_mem_read
                & (ex_rt != '0)
                & ((ex_rt == id_rs)
                 | (ex_rt == id_rt));

  assign lu_stall = lu_hit | lu_nz;
  assign md_stall = hz.id_md_use & md_nz;
  assign stall    = lu_stall | md_stall;

  assign br_taken = (epc == PCSRC_W'(PCSRC_BRANCH))
                  & hz.ex_alu_out0;

  assign jump = (ipc == PCSRC_W'(PCSRC_J))
              | (ipc == PCSRC_W'(PCSRC_JAL))
              | (ipc == PCSRC_W'(PCSRC_JR))
              | (ipc == PCSRC_W'(PCSRC_JALR));

  assign lu_clr  = br_taken | hz.exc_req;
  assign lu_load = lu_hit & ~lu_nz & ~lu_clr;
  assign md_load = hz.id_md_start & ~stall
                 & ~br_taken & ~hz.exc_req;

  hazard_down_counter #(
    .W (LU_W)
  ) u_lu_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (lu_load),
    .load_val_i (LU_W'(LOAD_LAT - 1)),
    .clr_i      (lu_clr),
    .nz_o       (lu_nz)
  );

  hazard_down_counter #(
    .W (MD_W)
  ) u_md_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (md_load),
    .load_val_i (MD_W'(MD_LAT)),
    .clr_i      (1'b0),
    .nz_o       (md_nz)
  );

  // Pipeline controls: exception > branch > stall > jump.
  always_comb begin
    ctl.pc_write     = 1'b1;
    ctl.if_id_write  = 1'b1;
    ctl.if_id_flush  = 1'b0;
    ctl.id_ex_flush  = 1'b0;
    ctl.ex_mem_flush = 1'b0;
    if (hz.exc_req) begin
      ctl.if_id_flush  = 1'b1;
      ctl.id_ex_flush  = 1'b1;
      ctl.ex_mem_flush = 1'b1;
    end else if (br_taken) begin
      ctl.if_id_flush = 1'b1;
      ctl.id_ex_flush = 1'b1;
    end else if (stall) begin
      ctl.pc_write    = 1'b0;
      ctl.if_id_write = 1'b0;
      ctl.id_ex_flush = 1'b1;
    end else if (jump) begin
      ctl.if_id_flush = 1'b1;
    end
  end

  // Saturating count of cycles with the PC frozen.
  always_comb begin
    stall_d = stall_q;
    if (!ctl.pc_write && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign hz.pc_write     = ctl.pc_write;
  assign hz.if_id_write  = ctl.if_id_write;
  assign hz.if_id_flush  = ctl.if_id_flush;
  assign hz.id_ex_flush  = ctl.id_ex_flush;
  assign hz.ex_mem_flush = ctl.ex_mem_flush;
  assign hz.md_busy      = md_nz;
  assign hz.stall_cycles = stall_q;

endmodule
